// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper_if
//  Description : Signal bundle between a truth-table sweeper and its
//                environment (the sweep requester plus the gate under test).
//                  start     - request a sweep (accepted only when not busy)
//                  expected  - expected 8-bit truth-table code
//                  dut_out   - output of the gate under test
//                  drv       - {in1,in2,in3} driven to the gate, in1 = MSB
//                  busy      - sweep in progress
//                  done      - one-cycle pulse at sweep completion
//                  code      - recovered truth-table code
//                  match     - code == captured expected
//                  mismatch  - code XOR captured expected
//                slave  : the sweeper
//                master : the environment (requester + gate under test)
//  Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_sweeper_if;
    logic       start;
    logic [7:0] expected;
    logic       dut_out;
    logic [2:0] drv;
    logic       busy;
    logic       done;
    logic [7:0] code;
    logic       match;
    logic [7:0] mismatch;

    modport slave (
        input  start,
        input  expected,
        input  dut_out,
        output drv,
        output busy,
        output done,
        output code,
        output match,
        output mismatch
    );

    modport master (
        output start,
        output expected,
        output dut_out,
        input  drv,
        input  busy,
        input  done,
        input  code,
        input  match,
        input  mismatch
    );
endinterface
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper
//  Description : Drives all eight input rows {in1,in2,in3} into a 3-input
//                combinational gate, holds each row SETTLE_CYCLES cycles,
//                samples the gate output and rebuilds the 8-bit truth-table
//                code (bit 7-r holds the output for row r). The recovered
//                code is compared against an expected code captured at
//                start.
//  Ports       : clk   - clock, rising edge
//                reset - synchronous, active-high reset
//                bus   - truth_table_sweeper_if.slave (start/expected/dut_out
//                        in; drv/busy/done/code/match/mismatch out)
//  Parameters  : SETTLE_CYCLES - cycles each row is held before sampling
//                                (must be >= 1)
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    truth_table_sweeper_if.slave   bus
);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("truth_table_sweeper: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_fin    = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [2:0]       r_row;
    logic [2:0]       w_row_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic [7:0]       r_code;
    logic [7:0]       r_expected;
    logic             r_match;
    logic [7:0]       r_mismatch;
    logic [7:0]       w_code_next;
    logic             w_accept;
    logic             w_sample;

    // A start in FIN is accepted exactly as in IDLE, giving back-to-back sweeps.
    assign w_accept = bus.start && (r_state != c_st_settle);
    assign w_sample = (r_state == c_st_settle) && (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_row   <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_cnt_next   = r_cnt;
        case (r_state)
            c_st_settle: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_next = '0;
                    if (r_row == 3'd7) begin
                        w_state_next = c_st_fin;
                    end else begin
                        w_row_next = r_row + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            c_st_idle, c_st_fin: begin
                if (bus.start) begin
                    w_state_next = c_st_settle;
                    w_row_next   = 3'd0;
                    w_cnt_next   = '0;
                end else begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
                w_row_next   = 3'd0;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (decoded from registered state, so glitch-free per cycle)
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy = (r_state == c_st_settle);
        bus.done = (r_state == c_st_fin);
        bus.drv  = (r_state == c_st_settle) ? r_row : 3'd0;
    end

    // ------------------------------------------------------------------
    // Result datapath
    // ------------------------------------------------------------------
    // Code with the current row's sample merged in; used so that match and
    // mismatch registered on the last sample already include row 7.
    always_comb begin
        w_code_next               = r_code;
        w_code_next[3'd7 - r_row] = bus.dut_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_code     <= 8'h00;
            r_expected <= 8'h00;
            r_match    <= 1'b0;
            r_mismatch <= 8'h00;
        end else if (w_accept) begin
            r_code     <= 8'h00;
            r_expected <= bus.expected;
            r_match    <= 1'b0;
            r_mismatch <= 8'h00;
        end else if (w_sample) begin
            r_code <= w_code_next;
            if (r_row == 3'd7) begin
                r_match    <= (w_code_next == r_expected);
                r_mismatch <= w_code_next ^ r_expected;
            end
        end
    end

    assign bus.code     = r_code;
    assign bus.match    = r_match;
    assign bus.mismatch = r_mismatch;

endmodule
`default_nettype wire

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential inverse of a 3-input truth-table gate module: drives all eight input rows into a combinational gate under test, samples its output, and reconstructs the 8-bit truth-table code (e.g. 0x5D).
- Sits on the characterization/verification side of the compiled-circuit flow.
- Optionally compares the recovered code against an expected code and reports per-row mismatches.

Parameters:
- SETTLE_CYCLES, 4, number of cycles each input row is held before the gate output is sampled; must be >= 1, and 0 is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a sweep; accepted only when busy=0
- expected  input  8  expected truth-table code; captured on start acceptance
- dut_out  input  1  output of the gate under test
- drv  output  3  {in1,in2,in3} driven to the gate under test; in1 is the MSB
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse when the sweep completes
- code  output  8  recovered truth-table code
- match  output  1  code == captured expected; valid from done until next acceptance
- mismatch  output  8  code XOR captured expected

Behaviour:
- Code convention: bit (7-r) of code holds the gate output for row r = {in1,in2,in3}. Row 000 maps to bit 7 and row 111 to bit 0, so 0x5D means rows 001, 011, 100, 101, 111 give 1.
- States:
  - IDLE
  - SETTLE (row counter 0..7, settle counter 0..SETTLE_CYCLES-1)
  - FIN
- Reset (synchronous, any state): state=IDLE, drv=000, busy=0, done=0, code=0x00, match=0, mismatch=0x00, captured expected=0x00. An aborted sweep never pulses done.
- IDLE:
  - start=1 at edge N → state=SETTLE, row=0, cnt=0, busy=1.
  - code is cleared to 0x00 and expected is captured at the same edge.
  - match and mismatch are cleared to 0.
- SETTLE:
  - drv=row throughout.
  - Each edge with cnt<SETTLE_CYCLES-1: cnt increments.
  - Edge with cnt==SETTLE_CYCLES-1: code[7-row] <= dut_out and cnt <= 0.
    - If row<7: row increments.
    - If row==7: state=FIN.
  - start is ignored while busy=1.
- FIN (one cycle):
  - done=1, busy=0.
  - match=(code==expected) and mismatch=code^expected are registered at the edge entering FIN.
  - drv returns to 000 on entry to FIN.
  - Next edge: state=IDLE and done=0.
  - start=1 during FIN is accepted exactly as in IDLE.
- Latency: start accepted at edge N → done high in the cycle after edge N+8*SETTLE_CYCLES. With SETTLE_CYCLES=4 that is 32 edges after acceptance.
- code, match and mismatch hold their values after FIN until the next accepted start or reset.
- dut_out is sampled raw with no synchronizer. SETTLE_CYCLES must exceed the latency of the gate under test; the bench checks this boundary.
- Row counter stops at 7 (no wrap); the settle counter wraps to 0 after each row.

Test Plan:
- Gate model = 3-input function 0x5D, expected=0x5D, SETTLE_CYCLES=4: pulse start → drv steps 000..111, each row held 4 cycles; done exactly 32 edges after acceptance; code=0x5D, match=1, mismatch=0x00; busy high for 32 cycles.
- Same gate, expected=0xFF → code=0x5D, match=0, mismatch=0xA2; then expected=0x00 rerun → mismatch=0x5D.
- start re-pulsed during rows 2 and 5 → ignored; a single done at the original time; code=0x5D.
- reset asserted during row 3 → next cycle drv=000, busy=0, code=0x00, match=0; no done pulse; a new start then completes with 0x5D.
- start held high through FIN → immediate restart: done high one cycle with busy=0, busy=1 on the next cycle, code cleared, second done 32 edges later.
- Gate model with a 2-cycle registered output delay: SETTLE_CYCLES=1 → recovered code ≠ 0x5D and match=0; SETTLE_CYCLES=3 → code=0x5D and match=1.
